// File: rtl/vga_timing_detector.sv
// rtl/vga_timing_detector.sv - measures VGA HS/VS timing, locks on a repeating mode, reports position
module vga_timing_detector #(
  parameter int SYNC_ACTIVE_LOW = 1,
  parameter int CNT_W           = 12,
  parameter int LOCK_FRAMES     = 2,
  parameter int TIMEOUT         = 4095
) (
  input  logic             pixel_clk,
  input  logic             reset,
  input  logic             VGA_HS,
  input  logic             VGA_VS,
  output logic [CNT_W-1:0] H_Total,
  output logic [CNT_W-1:0] H_SyncW,
  output logic [CNT_W-1:0] V_Total,
  output logic [CNT_W-1:0] V_SyncW,
  output logic [CNT_W-1:0] H_Pos,
  output logic [CNT_W-1:0] V_Pos,
  output logic             Locked,
  output logic             Mode_Change
);

  localparam logic             POL     = (SYNC_ACTIVE_LOW != 0);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TO_V    = CNT_W'(TIMEOUT);
  localparam logic [3:0]       LOCK_V  = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

  state_t             state_q, state_d;
  logic [3:0]         match_q, match_d;
  logic               hs_in_q, hs_in_d, vs_in_q, vs_in_d, hs_prev_q, hs_prev_d, vs_prev_q, vs_prev_d;
  logic               hs_ast_q, hs_ast_d, hs_dea_q, hs_dea_d, vs_ast_q, vs_ast_d, vs_dea_q, vs_dea_d;
  logic [CNT_W-1:0]   h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d, wd_cnt_q, wd_cnt_d;
  logic [CNT_W-1:0]   h_cand_q, h_cand_d, hw_cand_q, hw_cand_d, vw_cand_q, vw_cand_d;
  logic               line_bad_q, line_bad_d, line_first_q, line_first_d;
  logic               sat_q, sat_d, vs_seen_q, vs_seen_d, mode_change_q, mode_change_d;
  logic [4*CNT_W-1:0] frame_q, frame_d, frame_now;
  logic [CNT_W-1:0]   h_total_q, h_total_d, h_syncw_q, h_syncw_d;
  logic [CNT_W-1:0]   v_total_q, v_total_d, v_syncw_q, v_syncw_d;
  logic [CNT_W-1:0]   h_next, v_next;
  logic               h_full, v_full, tuple_ok, tuple_same, timeout;

  always_comb begin
    hs_in_d   = VGA_HS ^ POL;
    vs_in_d   = VGA_VS ^ POL;
    hs_prev_d = hs_in_q;
    vs_prev_d = vs_in_q;
    hs_ast_d  = hs_in_q & ~hs_prev_q;
    hs_dea_d  = ~hs_in_q & hs_prev_q;
    vs_ast_d  = vs_in_q & ~vs_prev_q;
    vs_dea_d  = ~vs_in_q & vs_prev_q;

    h_full = (h_cnt_q == CNT_MAX);
    v_full = (v_cnt_q == CNT_MAX);
    h_next = h_full ? h_cnt_q : h_cnt_q + 1'b1;
    v_next = v_full ? v_cnt_q : v_cnt_q + 1'b1;

    h_cnt_d   = hs_ast_q ? '0 : h_next;
    h_cand_d  = hs_ast_q ? h_next : h_cand_q;
    hw_cand_d = hs_dea_q ? h_next : hw_cand_q;
    vw_cand_d = vs_dea_q ? v_cnt_q : vw_cand_q;
    v_cnt_d   = vs_ast_q ? '0 : (hs_ast_q ? v_next : v_cnt_q);
    sat_d     = vs_ast_q ? 1'b0 : (sat_q | h_full | v_full);
    vs_seen_d = vs_seen_q | vs_ast_q;
    wd_cnt_d  = hs_ast_q ? '0 : ((wd_cnt_q == TO_V) ? wd_cnt_q : wd_cnt_q + 1'b1);
    timeout   = ~hs_ast_q & (wd_cnt_q == TO_V - 1'b1);

    // The first line of a frame has no in-frame predecessor, so it is not compared.
    line_bad_d   = line_bad_q;
    line_first_d = line_first_q;
    if (vs_ast_q) begin
      line_bad_d   = 1'b0;
      line_first_d = 1'b1;
    end else if (hs_ast_q) begin
      line_first_d = 1'b0;
      if (!line_first_q && (h_next != h_cand_q)) line_bad_d = 1'b1;
    end

    frame_now  = {h_cand_q, hw_cand_q, v_cnt_q, vw_cand_q};
    tuple_ok   = vs_seen_q & ~line_bad_q & ~sat_q & ~h_full & ~v_full;
    tuple_same = (frame_now == frame_q);
    frame_d    = vs_ast_q ? frame_now : frame_q;

    state_d       = state_q;
    match_d       = match_q;
    mode_change_d = 1'b0;
    h_total_d     = h_total_q;
    h_syncw_d     = h_syncw_q;
    v_total_d     = v_total_q;
    v_syncw_d     = v_syncw_q;
    if (timeout) begin
      state_d       = SEARCH;
      match_d       = '0;
      mode_change_d = (state_q == LOCKED);
    end else if (vs_ast_q) begin
      case (state_q)
        SEARCH: begin
          if (tuple_ok) begin
            state_d = VERIFY;
            match_d = '0;
          end
        end
        VERIFY: begin
          if (tuple_ok && tuple_same) begin
            match_d = match_q + 4'd1;
            if (match_d == LOCK_V) begin
              state_d   = LOCKED;
              h_total_d = h_cand_q;
              h_syncw_d = hw_cand_q;
              v_total_d = v_cnt_q;
              v_syncw_d = vw_cand_q;
            end
          end else begin
            match_d = '0;
          end
        end
        LOCKED: begin
          if (!(tuple_ok && tuple_same)) begin
            state_d       = SEARCH;
            match_d       = '0;
            mode_change_d = 1'b1;
          end
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      state_q <= SEARCH;        match_q <= '0;
      hs_in_q <= 1'b0;          vs_in_q <= 1'b0;
      hs_prev_q <= 1'b0;        vs_prev_q <= 1'b0;
      hs_ast_q <= 1'b0;         hs_dea_q <= 1'b0;
      vs_ast_q <= 1'b0;         vs_dea_q <= 1'b0;
      h_cnt_q <= '0;            v_cnt_q <= '0;            wd_cnt_q <= '0;
      h_cand_q <= '0;           hw_cand_q <= '0;          vw_cand_q <= '0;
      line_bad_q <= 1'b0;       line_first_q <= 1'b0;
      sat_q <= 1'b0;            vs_seen_q <= 1'b0;        mode_change_q <= 1'b0;
      frame_q <= '0;
      h_total_q <= '0;          h_syncw_q <= '0;
      v_total_q <= '0;          v_syncw_q <= '0;
    end else begin
      state_q <= state_d;       match_q <= match_d;
      hs_in_q <= hs_in_d;       vs_in_q <= vs_in_d;
      hs_prev_q <= hs_prev_d;   vs_prev_q <= vs_prev_d;
      hs_ast_q <= hs_ast_d;     hs_dea_q <= hs_dea_d;
      vs_ast_q <= vs_ast_d;     vs_dea_q <= vs_dea_d;
      h_cnt_q <= h_cnt_d;       v_cnt_q <= v_cnt_d;       wd_cnt_q <= wd_cnt_d;
      h_cand_q <= h_cand_d;     hw_cand_q <= hw_cand_d;   vw_cand_q <= vw_cand_d;
      line_bad_q <= line_bad_d; line_first_q <= line_first_d;
      sat_q <= sat_d;           vs_seen_q <= vs_seen_d;   mode_change_q <= mode_change_d;
      frame_q <= frame_d;
      h_total_q <= h_total_d;   h_syncw_q <= h_syncw_d;
      v_total_q <= v_total_d;   v_syncw_q <= v_syncw_d;
    end
  end

  assign H_Total     = h_total_q;
  assign H_SyncW     = h_syncw_q;
  assign V_Total     = v_total_q;
  assign V_SyncW     = v_syncw_q;
  assign H_Pos       = h_cnt_q;
  assign V_Pos       = v_cnt_q;
  assign Locked      = (state_q == LOCKED);
  assign Mode_Change = mode_change_q;

endmodule

// File: tb/tb_vga_timing_detector.sv
// tb/tb_vga_timing_detector.sv - directed checks of vga_timing_detector against a simple sync generator
module tb_vga_timing_detector;

  localparam int W   = 12;
  localparam int VT  = 10;
  localparam int HSW = 3;
  localparam int VSW = 2;
  localparam int OFF = 10;

  logic clk = 1'b0;
  logic reset;
  logic hs_lo, vs_lo, hs_hi, vs_hi;
  logic [W-1:0] lo_ht, lo_hw, lo_vt, lo_vw, lo_hp, lo_vp;
  logic [W-1:0] hi_ht, hi_hw, hi_vt, hi_vw, hi_hp, hi_vp;
  logic lo_lock, lo_mc, hi_lock, hi_mc;

  int checks = 0;
  int errors = 0;

  int hc, vc, ht, long_vc;
  bit run, vs_state, hs_act, hs_rise_f, vs_rise_f;

  always #5 clk = ~clk;

  vga_timing_detector #(.SYNC_ACTIVE_LOW(1), .CNT_W(W), .LOCK_FRAMES(2), .TIMEOUT(64)) dut_lo (
    .pixel_clk(clk), .reset(reset), .VGA_HS(hs_lo), .VGA_VS(vs_lo),
    .H_Total(lo_ht), .H_SyncW(lo_hw), .V_Total(lo_vt), .V_SyncW(lo_vw),
    .H_Pos(lo_hp), .V_Pos(lo_vp), .Locked(lo_lock), .Mode_Change(lo_mc));

  vga_timing_detector #(.SYNC_ACTIVE_LOW(0), .CNT_W(W), .LOCK_FRAMES(2), .TIMEOUT(64)) dut_hi (
    .pixel_clk(clk), .reset(reset), .VGA_HS(hs_hi), .VGA_VS(vs_hi),
    .H_Total(hi_ht), .H_SyncW(hi_hw), .V_Total(hi_vt), .V_SyncW(hi_vw),
    .H_Pos(hi_hp), .V_Pos(hi_vp), .Locked(hi_lock), .Mode_Change(hi_mc));

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive_pins();
    hs_lo = ~hs_act;
    vs_lo = ~vs_state;
    hs_hi = hs_act;
    vs_hi = vs_state;
  endtask

  // VS toggles mid-line (at hc==OFF) so every VS edge falls between HS edges.
  task automatic gen_advance();
    int len;
    bit nv;
    hs_rise_f = 1'b0;
    vs_rise_f = 1'b0;
    if (!run) begin
      hs_act   = 1'b0;
      vs_state = 1'b0;
    end else begin
      len = (vc == long_vc) ? ht + 1 : ht;
      if (hc >= len - 1) begin
        hc = 0;
        vc = (vc == VT - 1) ? 0 : vc + 1;
        hs_rise_f = 1'b1;
      end else begin
        hc++;
      end
      if (hc == OFF) begin
        nv = (vc < VSW);
        if (nv && !vs_state) vs_rise_f = 1'b1;
        vs_state = nv;
      end
      hs_act = (hc < HSW);
    end
    drive_pins();
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    gen_advance();
  endtask

  task automatic wait_vs(input int post);
    int n = 0;
    do begin
      cyc();
      n++;
    end while (!vs_rise_f && n < 5000);
    chk("vs_wait_bound", int'(vs_rise_f), 1);
    repeat (post) cyc();
  endtask

  task automatic wait_hs(input int post);
    int n = 0;
    do begin
      cyc();
      n++;
    end while (!hs_rise_f && n < 5000);
    chk("hs_wait_bound", int'(hs_rise_f), 1);
    repeat (post) cyc();
  endtask

  initial begin
    ht = 20; long_vc = -1; run = 1'b1;
    hc = 0; vc = 0; vs_state = 1'b0; hs_act = 1'b1;
    drive_pins();
    reset = 1'b1;

    // reset values
    repeat (3) cyc();
    chk("rst_locked", int'(lo_lock), 0);
    chk("rst_mode_change", int'(lo_mc), 0);
    chk("rst_h_total", int'(lo_ht), 0);
    chk("rst_v_syncw", int'(lo_vw), 0);
    chk("rst_h_pos", int'(lo_hp), 0);
    chk("rst_v_pos", int'(lo_vp), 0);
    chk("rst_hi_locked", int'(hi_lock), 0);
    reset = 1'b0;

    // clean 20/3/10/2 source: lock at the 4th VS edge, both polarities
    repeat (3) wait_vs(3);
    chk("s1_e3_locked", int'(lo_lock), 0);
    chk("s1_e3_hi_locked", int'(hi_lock), 0);
    wait_vs(2);
    chk("s1_e4m1_locked", int'(lo_lock), 0);
    cyc();
    chk("s1_locked", int'(lo_lock), 1);
    chk("s1_h_total", int'(lo_ht), 20);
    chk("s1_h_syncw", int'(lo_hw), 3);
    chk("s1_v_total", int'(lo_vt), 10);
    chk("s1_v_syncw", int'(lo_vw), 2);
    chk("s1_v_pos", int'(lo_vp), 0);
    chk("s1_hi_locked", int'(hi_lock), 1);
    chk("s1_hi_h_total", int'(hi_ht), 20);
    chk("s1_hi_h_syncw", int'(hi_hw), 3);
    chk("s1_hi_v_total", int'(hi_vt), 10);
    chk("s1_hi_v_syncw", int'(hi_vw), 2);
    wait_hs(3);
    chk("s1_h_pos_zero", int'(lo_hp), 0);
    cyc();
    chk("s1_h_pos_one", int'(lo_hp), 1);

    // switch to a 24-cycle line while locked
    ht = 24;
    wait_vs(2);
    chk("s2_pre_locked", int'(lo_lock), 1);
    chk("s2_pre_mc", int'(lo_mc), 0);
    cyc();
    chk("s2_unlock", int'(lo_lock), 0);
    chk("s2_mc_pulse", int'(lo_mc), 1);
    chk("s2_hold_h_total", int'(lo_ht), 20);
    cyc();
    chk("s2_mc_one_cycle", int'(lo_mc), 0);
    wait_vs(3);
    chk("s2_f1_locked", int'(lo_lock), 0);
    wait_vs(3);
    chk("s2_f2_locked", int'(lo_lock), 0);
    chk("s2_f2_hold_h_total", int'(lo_ht), 20);
    wait_vs(3);
    chk("s2_relock", int'(lo_lock), 1);
    chk("s2_h_total", int'(lo_ht), 24);
    chk("s2_h_syncw", int'(lo_hw), 3);
    chk("s2_v_total", int'(lo_vt), 10);

    // HS stops: forced unlock TIMEOUT cycles after the last HS strobe
    wait_hs(0);
    run = 1'b0;
    repeat (66) cyc();
    chk("s3_pre_locked", int'(lo_lock), 1);
    chk("s3_pre_mc", int'(lo_mc), 0);
    cyc();
    chk("s3_timeout_locked", int'(lo_lock), 0);
    chk("s3_timeout_mc", int'(lo_mc), 1);
    cyc();
    chk("s3_mc_one_cycle", int'(lo_mc), 0);
    chk("s3_hold_h_total", int'(lo_ht), 24);

    // resume and relock, then reset mid-frame
    run = 1'b1;
    for (int i = 0; i < 8 && !lo_lock; i++) wait_vs(3);
    chk("s4_relock_after_timeout", int'(lo_lock), 1);
    repeat (100) cyc();
    reset = 1'b1;
    cyc();
    chk("s4_rst_locked", int'(lo_lock), 0);
    chk("s4_rst_mc", int'(lo_mc), 0);
    chk("s4_rst_h_total", int'(lo_ht), 0);
    chk("s4_rst_h_syncw", int'(lo_hw), 0);
    chk("s4_rst_v_total", int'(lo_vt), 0);
    chk("s4_rst_v_syncw", int'(lo_vw), 0);
    chk("s4_rst_h_pos", int'(lo_hp), 0);
    chk("s4_rst_v_pos", int'(lo_vp), 0);
    reset = 1'b0;
    repeat (3) wait_vs(3);
    chk("s4_e3_locked", int'(lo_lock), 0);
    wait_vs(3);
    chk("s4_e4_locked", int'(lo_lock), 1);
    chk("s4_h_total", int'(lo_ht), 24);

    // one 21-cycle line in the frame that would have completed the first match
    ht = 20;
    repeat (60) cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    repeat (2) wait_vs(3);
    long_vc = 4;
    wait_vs(3);
    long_vc = -1;
    chk("s5_e3_locked", int'(lo_lock), 0);
    wait_vs(3);
    chk("s5_e4_locked", int'(lo_lock), 0);
    wait_vs(3);
    chk("s5_e5_locked", int'(lo_lock), 1);
    chk("s5_h_total", int'(lo_ht), 20);
    chk("s5_v_total", int'(lo_vt), 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
